// File: rtl/cgia_crtc.sv
// CGIA CRT timing generator: prescaled dot/line counters decoded into registered sync,
// fetch/visible enables and line-buffer bank select. Optional raster IRQ: CGIA_RASTER_IRQ_EN.
module cgia_crtc #(
    parameter int unsigned H_TOTAL      = 800,
    parameter int unsigned H_DISP       = 640,
    parameter int unsigned H_SYNC_START = 656,
    parameter int unsigned H_SYNC_WIDTH = 96,
    parameter int unsigned V_TOTAL      = 525,
    parameter int unsigned V_DISP       = 480,
    parameter int unsigned V_SYNC_START = 490,
    parameter int unsigned V_SYNC_WIDTH = 2,
    parameter int unsigned CLKS_PER_DOT = 2
) (
    input  logic       clk_i,
    input  logic       reset_i,
`ifdef CGIA_RASTER_IRQ_EN
    input  logic [9:0] irq_line_i,
    output logic       irq_o,
`endif
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       den_o,
    output logic       pen_o,
    output logic       bank_o,
    output logic       dot_o,
    output logic [9:0] hctr_o,
    output logic [9:0] vctr_o
);

    localparam int unsigned PW = (CLKS_PER_DOT > 1) ? $clog2(CLKS_PER_DOT) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLKS_PER_DOT - 1);
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_DISP_W = 11'(H_DISP);
    localparam logic [10:0] V_DISP_W = 11'(V_DISP);
    localparam logic [10:0] HS_BEG   = 11'(H_SYNC_START);
    localparam logic [10:0] HS_END   = 11'(H_SYNC_START + H_SYNC_WIDTH);
    localparam logic [10:0] VS_BEG   = 11'(V_SYNC_START);
    localparam logic [10:0] VS_END   = 11'(V_SYNC_START + V_SYNC_WIDTH);

`ifndef SYNTHESIS
    if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLKS_PER_DOT < 1 ||
        H_DISP > H_SYNC_START || H_SYNC_START + H_SYNC_WIDTH > H_TOTAL ||
        V_DISP > V_SYNC_START || V_SYNC_START + V_SYNC_WIDTH > V_TOTAL) begin : g_param_err
        $error("cgia_crtc: illegal timing parameters");
    end
`endif

    logic [PW-1:0] presc_q, presc_d;
    logic [9:0]    hctr_q, hctr_d;
    logic [9:0]    vctr_q, vctr_d;
    logic          run_q;
    logic          hsync_q, hsync_d, vsync_q, vsync_d;
    logic          den_q, den_d, pen_q, pen_d;
    logic          bank_q, bank_d, dot_q, dot_d;
    logic          tick, h_wrap, line_start;
    logic [9:0]    v_next;
    logic [10:0]   h_ext, v_ext, vn_ext;

    always_comb begin
        tick       = run_q && (presc_q == PRESC_MAX);
        h_wrap     = (hctr_q == H_LAST);
        line_start = tick && h_wrap;

        presc_d = presc_q;
        if (run_q) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end

        hctr_d = hctr_q;
        vctr_d = vctr_q;
        if (tick) begin
            if (h_wrap) begin
                hctr_d = '0;
                vctr_d = (vctr_q == V_LAST) ? '0 : vctr_q + 1'b1;
            end else begin
                hctr_d = hctr_q + 1'b1;
            end
        end

        // Decode the post-edge counters so outputs move in the same clock as the counters.
        h_ext  = {1'b0, hctr_d};
        v_ext  = {1'b0, vctr_d};
        v_next = (vctr_d == V_LAST) ? '0 : vctr_d + 1'b1;
        vn_ext = {1'b0, v_next};

        hsync_d = (h_ext >= HS_BEG) && (h_ext < HS_END);
        vsync_d = (v_ext >= VS_BEG) && (v_ext < VS_END);
        pen_d   = (h_ext < H_DISP_W) && (v_ext < V_DISP_W);
        den_d   = (vn_ext < V_DISP_W);
        bank_d  = bank_q ^ (line_start && (v_ext < V_DISP_W));
        dot_d   = tick;
    end

    // run_q holds the counters on the first edge after reset so that edge shows (0,0).
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            run_q   <= 1'b0;
            presc_q <= '0;
            hctr_q  <= '0;
            vctr_q  <= '0;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
            den_q   <= 1'b0;
            pen_q   <= 1'b0;
            bank_q  <= 1'b0;
            dot_q   <= 1'b0;
        end else begin
            run_q   <= 1'b1;
            presc_q <= presc_d;
            hctr_q  <= hctr_d;
            vctr_q  <= vctr_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            den_q   <= den_d;
            pen_q   <= pen_d;
            bank_q  <= bank_d;
            dot_q   <= dot_d;
        end
    end

    assign hsync_o = hsync_q;
    assign vsync_o = vsync_q;
    assign den_o   = den_q;
    assign pen_o   = pen_q;
    assign bank_o  = bank_q;
    assign dot_o   = dot_q;
    assign hctr_o  = hctr_q;
    assign vctr_o  = vctr_q;

`ifdef CGIA_RASTER_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = line_start && (vctr_d == irq_line_i);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq_o = irq_q;
`endif

endmodule
